sse_framed: RTL and testbench

SSE_FRAMED -- requirements
Module: sse_framed

---
 rtl/sse_framed.sv | 118 +++++++++++
 tb/tb_sse_framed.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sse_framed.sv
// rtl/sse_framed.sv - sum of squared error (A-B)^2 over frames, valid/ready in and out, flush emits partial frame
module sse_framed #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 48,
  parameter int FRAME_LEN = 64,
  parameter int SAT       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] A,
  input  logic signed [DATA_W-1:0] B,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         Y,
  output logic [15:0]              out_count,
  output logic                     ovf
);

  localparam int DW  = DATA_W + 1;
  localparam int SW  = 2 * DATA_W + 1;
  localparam int AW1 = ACC_W + 1;

  typedef enum logic [1:0] {RUN, DRAIN, EMIT} state_t;

  state_t                state, state_nxt;
  logic                  stall, accept;
  logic                  v1, v2;
  logic signed [DW-1:0]  d;
  logic signed [SW-1:0]  d_ext;
  logic [SW-1:0]         sq;
  logic [ACC_W-1:0]      acc, acc_add;
  logic [15:0]           cnt, cnt_inc;
  logic                  sticky, ovf_new, frame_done, s3_go;
  logic [AW1-1:0]        sum;

  assign stall    = out_valid && !out_ready;
  assign in_ready = (state == RUN) && !stall;
  assign accept   = in_valid && in_ready;

  assign d_ext      = SW'(d);
  assign sum        = {1'b0, acc} + AW1'(sq);
  assign ovf_new    = sum[ACC_W];
  assign acc_add    = (ovf_new && SAT != 0) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  // Saturating increment only matters in running mode; framed cnt never reaches 65535+1.
  assign cnt_inc    = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign frame_done = (FRAME_LEN != 0) && (cnt_inc == 16'(FRAME_LEN));
  assign s3_go      = v2 && !stall;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = DRAIN;
      DRAIN:   if (!v1 && !v2 && !stall) state_nxt = EMIT;
      EMIT:    if (!stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      v1        <= 1'b0;
      v2        <= 1'b0;
      d         <= '0;
      sq        <= '0;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      Y         <= '0;
      out_count <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!stall) begin
        v1 <= accept;
        if (accept) d <= DW'(A) - DW'(B);
        v2 <= v1;
        if (v1) sq <= d_ext * d_ext;
      end
      if (out_ready) out_valid <= 1'b0;
      // A load on the same edge as a consume overrides the clear above.
      if (s3_go) begin
        if (frame_done) begin
          Y         <= acc_add;
          out_count <= 16'(FRAME_LEN);
          ovf       <= sticky | ovf_new;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          sticky    <= 1'b0;
        end else begin
          acc    <= acc_add;
          cnt    <= cnt_inc;
          sticky <= sticky | ovf_new;
          if (FRAME_LEN == 0) begin
            Y         <= acc_add;
            out_count <= cnt_inc;
            ovf       <= sticky | ovf_new;
            out_valid <= 1'b1;
          end
        end
      end else if (state == EMIT && !stall) begin
        Y         <= acc;
        out_count <= cnt;
        ovf       <= sticky;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        sticky    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sse_framed.sv
// tb/tb_sse_framed.sv - bench for sse_framed across several parameter sets
module tb_sse_framed;

  localparam int NI = 7;

  function automatic int fl_of(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2, 3: return 4;
      4: return 2;
      5: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int acc_w_of(input int g);
    return (g == 2 || g == 3) ? 17 : 48;
  endfunction

  function automatic int sat_of(input int g);
    return (g == 3) ? 0 : 1;
  endfunction

  logic        clk, rst;
  logic        iv[NI], fl[NI], ordy[NI], ir[NI], ov[NI], of[NI];
  logic [7:0]  a[NI], b[NI];
  logic [47:0] y[NI];
  logic [15:0] oc[NI];

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int AW = acc_w_of(g);
    logic [AW-1:0] yl;
    sse_framed #(.DATA_W(8), .ACC_W(AW), .FRAME_LEN(fl_of(g)), .SAT(sat_of(g))) dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .A(a[g]), .B(b[g]),
      .flush(fl[g]), .out_valid(ov[g]), .out_ready(ordy[g]), .Y(yl), .out_count(oc[g]), .ovf(of[g]));
    assign y[g] = 48'(yl);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint y; int c; bit o; } res_t;
  res_t   q[NI][$];
  longint m_acc[NI];
  int     m_cnt[NI], acc_n[NI], res_n[NI];
  bit     m_st[NI], last_ir[NI], last_fl[NI];
  int     checks = 0, errors = 0;

  typedef struct { int g; int av; int bv; int reps; longint ey; int ec; bit eo; } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_res(input int g, input longint yv, input int c, input bit o);
    res_t r;
    r.y = yv; r.c = c; r.o = o;
    q[g].push_back(r);
  endtask

  task automatic model_clear(input int g);
    m_acc[g] = 0; m_cnt[g] = 0; m_st[g] = 1'b0;
  endtask

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      model_clear(g);
      q[g].delete();
      acc_n[g] = 0; res_n[g] = 0; last_ir[g] = 1'b0; last_fl[g] = 1'b0;
    end
  endtask

  // Reference: squared difference added with clamp or modular wrap, emitted per frame or per sample.
  task automatic model_sample(input int g, input logic [7:0] av, input logic [7:0] bv);
    int     dd;
    longint sqv, mx, s;
    bit     o;
    dd  = int'($signed(av)) - int'($signed(bv));
    sqv = longint'(dd) * longint'(dd);
    mx  = (longint'(1) << acc_w_of(g)) - 1;
    s   = m_acc[g] + sqv;
    o   = (s > mx);
    m_acc[g] = o ? ((sat_of(g) != 0) ? mx : s - (mx + 1)) : s;
    m_cnt[g]++;
    m_st[g] = m_st[g] | o;
    if (fl_of(g) != 0 && m_cnt[g] == fl_of(g)) begin
      push_res(g, m_acc[g], m_cnt[g], m_st[g]);
      model_clear(g);
    end else if (fl_of(g) == 0) begin
      push_res(g, m_acc[g], (m_cnt[g] > 65535) ? 65535 : m_cnt[g], m_st[g]);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      if (ov[g] && ordy[g]) begin
        res_n[g]++;
        if (q[g].size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected[%0d]: got result y=%0d with none expected", g, y[g]);
        end else begin
          res_t r;
          r = q[g].pop_front();
          chk($sformatf("sb_y[%0d]", g), y[g], r.y);
          chk($sformatf("sb_count[%0d]", g), oc[g], r.c);
          chk($sformatf("sb_ovf[%0d]", g), of[g], r.o);
        end
      end
      if (iv[g] && ir[g]) begin
        acc_n[g]++;
        model_sample(g, a[g], b[g]);
      end
      if (fl[g]) begin
        push_res(g, m_acc[g], m_cnt[g], m_st[g]);
        model_clear(g);
      end
      last_ir[g] = ir[g];
      last_fl[g] = fl[g];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_result(input int g, input logic [63:0] ey, input logic [63:0] ec,
                             input logic [63:0] eo, input string nm);
    int k;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!ov[g] && k < 30);
    chk({nm, "_valid"}, ov[g], 1);
    chk({nm, "_y"}, y[g], ey);
    chk({nm, "_count"}, oc[g], ec);
    chk({nm, "_ovf"}, of[g], eo);
  endtask

  initial begin
    int base;
    tbl[0] = '{1,  127, -128, 1,  65025, 1, 1'b0};
    tbl[1] = '{1, -128,  127, 1,  65025, 1, 1'b0};
    tbl[2] = '{1,    0,    0, 1,      0, 1, 1'b0};
    tbl[3] = '{1,   -7,    5, 1,    144, 1, 1'b0};
    tbl[4] = '{2,  127, -128, 4, 131071, 4, 1'b1};
    tbl[5] = '{3,  127, -128, 4, 129028, 4, 1'b1};
    tbl[6] = '{2,   10,    3, 4,    196, 4, 1'b0};
    tbl[7] = '{3,   10,    3, 4,    196, 4, 1'b0};
    tbl[8] = '{0, -128, -128, 4,      0, 4, 1'b0};

    rst = 1'b0;
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; fl[g] = 1'b0; ordy[g] = 1'b1; a[g] = '0; b[g] = '0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("reset_valid[%0d]", g), ov[g], 0);
      chk($sformatf("reset_y[%0d]", g), y[g], 0);
      chk($sformatf("reset_count[%0d]", g), oc[g], 0);
    end
    rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) chk($sformatf("reset_in_ready[%0d]", g), ir[g], 1);

    // Four back-to-back samples, result exactly three edges after the last accept.
    iv[0] = 1'b1;
    a[0] = 8'd3;   b[0] = 8'd1;  cyc();
    a[0] = -8'sd2; b[0] = 8'd2;  cyc();
    a[0] = 8'd10;  b[0] = -8'sd5; cyc();
    a[0] = 8'd0;   b[0] = 8'd0;  cyc();
    iv[0] = 1'b0;
    cyc(); chk("lat_edge2_valid", ov[0], 0);
    cyc(); chk("lat_edge3_valid", ov[0], 1);
    chk("lat_y", y[0], 245); chk("lat_count", oc[0], 4); chk("lat_ovf", of[0], 0);
    cyc(); chk("lat_single_pulse", ov[0], 0);

    for (int i = 0; i < 9; i++) begin
      iv[tbl[i].g] = 1'b1;
      a[tbl[i].g] = 8'(tbl[i].av);
      b[tbl[i].g] = 8'(tbl[i].bv);
      for (int r = 0; r < tbl[i].reps; r++) cyc();
      iv[tbl[i].g] = 1'b0;
      wait_result(tbl[i].g, tbl[i].ey, tbl[i].ec, tbl[i].eo, $sformatf("tbl%0d", i));
    end

    // Flush raised with the frame's last sample: full frame, then an empty remainder.
    iv[0] = 1'b1; b[0] = 8'd0;
    for (int i = 1; i <= 4; i++) begin
      a[0] = 8'(i);
      fl[0] = (i == 4);
      cyc();
    end
    iv[0] = 1'b0; fl[0] = 1'b0;
    wait_result(0, 30, 4, 0, "drain_frame");
    wait_result(0, 0, 0, 0, "drain_rem");

    // Consumer stall on FRAME_LEN=2: hold for 10 cycles, then nothing lost.
    base = res_n[4];
    iv[4] = 1'b1; b[4] = 8'd0;
    for (int k = 0; k < 20 && !ov[4]; k++) begin a[4] = 8'(acc_n[4] + 1); cyc(); end
    chk("stall_first_valid", ov[4], 1);
    ordy[4] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a[4] = 8'(acc_n[4] + 1);
      #1;
      chk("stall_in_ready", ir[4], 0);
      chk("stall_y_held", y[4], 5);
      chk("stall_valid_held", ov[4], 1);
      cyc();
    end
    ordy[4] = 1'b1;
    for (int k = 0; k < 40 && acc_n[4] < 8; k++) begin a[4] = 8'(acc_n[4] + 1); cyc(); end
    iv[4] = 1'b0;
    repeat (10) cyc();
    chk("stall_results", res_n[4] - base, 4);
    chk("stall_sb_empty", q[4].size(), 0);

    // Flush after 3 samples on FRAME_LEN=8, then flush with nothing pending.
    for (int i = 0; i < 3; i++) begin
      iv[5] = 1'b1; a[5] = 8'(i + 2); b[5] = 8'd0; cyc();
    end
    iv[5] = 1'b0; fl[5] = 1'b1; cyc(); fl[5] = 1'b0;
    for (int k = 0; k < 20 && !ov[5]; k++) begin chk("flush_in_ready", ir[5], 0); cyc(); end
    chk("flush_valid", ov[5], 1); chk("flush_y", y[5], 29);
    chk("flush_count", oc[5], 3); chk("flush_ovf", of[5], 0);
    cyc();
    fl[5] = 1'b1; cyc(); fl[5] = 1'b0;
    wait_result(5, 0, 0, 0, "flush_empty");

    // Reset mid-frame and with a stalled result held at the output.
    ordy[6] = 1'b0;
    iv[5] = 1'b1; iv[6] = 1'b1; a[5] = 8'd3; a[6] = 8'd3; b[5] = 8'd0; b[6] = 8'd0;
    repeat (5) cyc();
    iv[5] = 1'b0; iv[6] = 1'b0;
    chk("rst_pre_valid", ov[6], 1);
    chk("rst_pre_y", y[6], 9);
    rst = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_async_valid[%0d]", g), ov[g], 0);
      chk($sformatf("rst_async_y[%0d]", g), y[g], 0);
      chk($sformatf("rst_async_count[%0d]", g), oc[g], 0);
      chk($sformatf("rst_async_ovf[%0d]", g), of[g], 0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    ordy[6] = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) chk($sformatf("rst_in_ready[%0d]", g), ir[g], 1);
    for (int i = 0; i < 8; i++) begin
      iv[5] = 1'b1; a[5] = 8'(i + 1); b[5] = 8'd0; cyc();
    end
    iv[5] = 1'b0;
    wait_result(5, 204, 8, 0, "post_rst");
    iv[6] = 1'b1; a[6] = 8'd2; b[6] = 8'd0; cyc(); iv[6] = 1'b0;
    wait_result(6, 4, 1, 0, "post_rst_run");

    // Random traffic, back-pressure and flushes on every instance against the reference.
    for (int n = 0; n < 600; n++) begin
      for (int g = 0; g < NI; g++) begin
        iv[g]   = ($urandom % 4) != 0;
        a[g]    = 8'($urandom);
        b[g]    = 8'($urandom);
        ordy[g] = ($urandom % 4) != 0;
        fl[g]   = last_ir[g] && !last_fl[g] && (($urandom % 50) == 0);
      end
      cyc();
    end
    for (int g = 0; g < NI; g++) begin
      iv[g] = 1'b0; fl[g] = 1'b0; ordy[g] = 1'b1;
    end
    repeat (30) cyc();
    for (int g = 0; g < NI; g++) chk($sformatf("rand_sb_empty[%0d]", g), q[g].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
